// File: rtl/cmsdk_apb_flash_prog_ctrl_pkg.sv
// Shared constants for the flash program/erase sequencer: register map,
// command key and codes, FSM states and STATUS bit positions.
package cmsdk_flash_prog_ctrl_pkg;

  localparam logic [9:0] OFS_ADDR   = 10'h000;
  localparam logic [9:0] OFS_WDATA  = 10'h001;
  localparam logic [9:0] OFS_CMD    = 10'h002;
  localparam logic [9:0] OFS_STATUS = 10'h003;
  localparam logic [9:0] OFS_INTEN  = 10'h004;

  localparam logic [15:0] CMD_KEY   = 16'hA5A5;
  localparam logic [1:0]  CMD_PROG  = 2'b01;
  localparam logic [1:0]  CMD_ERASE = 2'b10;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/cmsdk_apb_flash_prog_ctrl_if.sv
// APB slave bus bundle for the flash program/erase sequencer.
interface cmsdk_apb_flash_prog_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/cmsdk_apb_flash_prog_ctrl_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of a phase.
module cmsdk_flash_prog_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cmsdk_apb_flash_prog_ctrl.sv
// APB program/erase sequencer for the 32-bit embedded flash macro.
// Defining FLASH_PROG_CTRL_IRQ_EN adds the INTEN register and the IRQ output.
//
// state | meaning
// IDLE  | read bridge owns FLASHADDR; waiting for a valid CMD write
// SETUP | address/data settle before the strobe (T_SETUP cycles)
// PULSE | FLASHPROG or FLASHERASE asserted (T_PROG / T_ERASE cycles)
// HOLD  | address/data held after the strobe (T_SETUP cycles)
module cmsdk_apb_flash_prog_ctrl
  import cmsdk_flash_prog_ctrl_pkg::*;
#(
  parameter int AW      = 16,
  parameter int CW      = 16,
  parameter int T_SETUP = 2,
  parameter int T_PROG  = 40,
  parameter int T_ERASE = 4000
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  cmsdk_apb_flash_prog_ctrl_if.slave apb,
  input  logic [AW-3:0]              RDADDR,
  output logic [AW-3:0]              FLASHADDR,
  output logic [31:0]                FLASHWDATA,
  output logic                       FLASHPROG,
  output logic                       FLASHERASE,
  output logic                       BUSY
`ifdef FLASH_PROG_CTRL_IRQ_EN
  ,
  output logic                       IRQ
`endif
);

  localparam logic [CW-1:0] SETUP_M1 = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PROG_M1  = CW'(T_PROG - 1);
  localparam logic [CW-1:0] ERASE_M1 = CW'(T_ERASE - 1);

  state_t        state;
  logic          op_erase;
  logic [AW-3:0] addr_q;
  logic [31:0]   wdata_q;
  logic          done_q, err_q;
  logic          tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
  logic [31:0]   rdata;

  logic wr_en, rd_en, guarded, wr_blocked, wr_ok, sts_wr;
  logic cmd_wr, cmd_valid, cmd_bad, op_end;

  assign wr_en      = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en      = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign guarded    = (apb.PADDR == OFS_ADDR) | (apb.PADDR == OFS_WDATA) |
                      (apb.PADDR == OFS_CMD);
  assign wr_blocked = wr_en & guarded & BUSY;
  assign wr_ok      = wr_en & ~wr_blocked;
  assign sts_wr     = wr_en & (apb.PADDR == OFS_STATUS);
  assign cmd_wr     = wr_ok & (apb.PADDR == OFS_CMD);
  assign cmd_valid  = cmd_wr & (apb.PWDATA[31:16] == CMD_KEY) &
                      ((apb.PWDATA[1:0] == CMD_PROG) | (apb.PWDATA[1:0] == CMD_ERASE));
  assign cmd_bad    = cmd_wr & ~cmd_valid;
  assign op_end     = (state == S_HOLD) & tmr_zero;

  // Hardware sets are OR-ed in after the W1C clear so a coincident set wins.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (wr_ok && apb.PADDR == OFS_ADDR)  addr_q  <= apb.PWDATA[AW-3:0];
      if (wr_ok && apb.PADDR == OFS_WDATA) wdata_q <= apb.PWDATA;
      done_q <= (done_q & ~(sts_wr & apb.PWDATA[ST_DONE])) | op_end;
      err_q  <= (err_q & ~(sts_wr & apb.PWDATA[ST_ERR])) | cmd_bad | wr_blocked;
    end
  end

`ifdef FLASH_PROG_CTRL_IRQ_EN
  logic [1:0] inten_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      inten_q <= '0;
      IRQ     <= 1'b0;
    end else begin
      if (wr_en && apb.PADDR == OFS_INTEN) inten_q <= apb.PWDATA[1:0];
      IRQ <= |({err_q, done_q} & inten_q);
    end
  end
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETUP_M1;
    case (state)
      S_IDLE:  tmr_load = cmd_valid;
      S_SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = op_erase ? ERASE_M1 : PROG_M1;
      end
      S_PULSE: tmr_load = tmr_zero;
      default: tmr_load = 1'b0;
    endcase
  end

  cmsdk_flash_prog_timer #(.CW(CW)) u_timer (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= S_IDLE;
      op_erase   <= 1'b0;
      BUSY       <= 1'b0;
      FLASHPROG  <= 1'b0;
      FLASHERASE <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          state    <= S_SETUP;
          op_erase <= (apb.PWDATA[1:0] == CMD_ERASE);
          BUSY     <= 1'b1;
        end
        S_SETUP: if (tmr_zero) begin
          state      <= S_PULSE;
          FLASHPROG  <= ~op_erase;
          FLASHERASE <= op_erase;
        end
        S_PULSE: if (tmr_zero) begin
          state      <= S_HOLD;
          FLASHPROG  <= 1'b0;
          FLASHERASE <= 1'b0;
        end
        S_HOLD: if (tmr_zero) begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ADDR/WDATA cannot be written while BUSY, so they serve as the latched operands.
  assign FLASHADDR  = BUSY ? addr_q  : RDADDR;
  assign FLASHWDATA = BUSY ? wdata_q : '0;

  always_comb begin
    rdata = '0;
    case (apb.PADDR)
      OFS_ADDR:   rdata = 32'(addr_q);
      OFS_WDATA:  rdata = wdata_q;
      OFS_STATUS: rdata = {29'd0, err_q, done_q, BUSY};
`ifdef FLASH_PROG_CTRL_IRQ_EN
      OFS_INTEN:  rdata = {30'd0, inten_q};
`endif
      default:    rdata = '0;
    endcase
  end

  assign apb.PRDATA  = rd_en ? rdata : '0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = wr_blocked;

endmodule

// File: tb/tb_cmsdk_apb_flash_prog_ctrl.sv
// Randomized bench for the flash program/erase sequencer against a
// timing-window reference model, plus directed literal checks.
module tb_cmsdk_apb_flash_prog_ctrl;

  localparam int TS = 2;
  localparam int TP = 40;
  localparam int TE = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] rdaddr = 14'h1234;
  logic [13:0] flashaddr;
  logic [31:0] flashwdata;
  logic        flashprog, flasherase, busy;
`ifdef FLASH_PROG_CTRL_IRQ_EN
  logic        irq;
`endif

  cmsdk_apb_flash_prog_ctrl_if bus();

  cmsdk_apb_flash_prog_ctrl #(.AW(16), .CW(16), .T_SETUP(TS), .T_PROG(TP), .T_ERASE(TE)) dut (
    .PCLK       (clk),
    .PRESETn    (rst_n),
    .apb        (bus),
    .RDADDR     (rdaddr),
    .FLASHADDR  (flashaddr),
    .FLASHWDATA (flashwdata),
    .FLASHPROG  (flashprog),
    .FLASHERASE (flasherase),
    .BUSY       (busy)
`ifdef FLASH_PROG_CTRL_IRQ_EN
    ,
    .IRQ        (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: register contents plus the time window of the current operation.
  logic [13:0] m_addr = '0, m_addr_lat = '0;
  logic [31:0] m_wdata = '0, m_wdata_lat = '0;
  logic        m_done = 1'b0, m_err = 1'b0, m_erase = 1'b0;
  logic [1:0]  m_inten = '0;
  logic        m_irq = 1'b0;
  int          m_start = -1, m_len = 0, m_tp = 0;

  function automatic logic m_busy(input int c);
    return (m_start >= 0) && (c >= m_start) && (c < m_start + m_len);
  endfunction

  function automatic logic m_pulse(input int c);
    return (m_start >= 0) && (c >= m_start + TS) && (c < m_start + TS + m_tp);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [9:0] a, input logic b);
    case (a)
      10'd0:   return {18'd0, m_addr};
      10'd1:   return m_wdata;
      10'd3:   return {29'd0, m_err, m_done, b};
`ifdef FLASH_PROG_CTRL_IRQ_EN
      10'd4:   return {30'd0, m_inten};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic        mb, mw;
  logic [9:0]  ma;
  logic [31:0] md;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_addr = '0; m_wdata = '0; m_done = 1'b0; m_err = 1'b0;
      m_inten = '0; m_irq = 1'b0; m_start = -1;
    end else begin
      mb = m_busy(cyc);
      mw = bus.PSEL && bus.PENABLE && bus.PWRITE;
      ma = bus.PADDR;
      md = bus.PWDATA;
`ifdef FLASH_PROG_CTRL_IRQ_EN
      m_irq = |({m_err, m_done} & m_inten);
      if (mw && ma == 10'd4) m_inten = md[1:0];
`endif
      if (mw && ma == 10'd3) begin
        if (md[1]) m_done = 1'b0;
        if (md[2]) m_err = 1'b0;
      end
      if (mb && cyc == m_start + m_len - 1) m_done = 1'b1;
      if (mw && mb && ma <= 10'd2) m_err = 1'b1;
      else if (mw && !mb) begin
        if (ma == 10'd0) m_addr = md[13:0];
        if (ma == 10'd1) m_wdata = md;
        if (ma == 10'd2) begin
          if (md[31:16] == 16'hA5A5 && (md[1:0] == 2'd1 || md[1:0] == 2'd2)) begin
            m_start = cyc + 1;
            m_erase = (md[1:0] == 2'd2);
            m_tp = m_erase ? TE : TP;
            m_len = 2 * TS + m_tp;
            m_addr_lat = m_addr;
            m_wdata_lat = m_wdata;
          end else m_err = 1'b1;
        end
      end
    end
    cyc++;
  end

  logic cb, cp;

  always @(negedge clk) begin
    if (rst_n) begin
      cb = m_busy(cyc);
      cp = m_pulse(cyc);
      chk("busy", busy, cb);
      chk("flashprog", flashprog, cp && !m_erase);
      chk("flasherase", flasherase, cp && m_erase);
      chk("flashaddr", flashaddr, cb ? m_addr_lat : rdaddr);
      chk("flashwdata", flashwdata, cb ? m_wdata_lat : 32'd0);
      chk("pready", bus.PREADY, 1'b1);
      chk("pslverr", bus.PSLVERR,
          bus.PSEL && bus.PENABLE && bus.PWRITE && cb && bus.PADDR <= 10'd2);
      if (!(bus.PSEL && bus.PENABLE && !bus.PWRITE))
        chk("prdata_idle", bus.PRDATA, 32'd0);
      else if (bus.PADDR == 10'd3 || !cb)
        chk("prdata", bus.PRDATA, exp_rd(bus.PADDR, cb));
`ifdef FLASH_PROG_CTRL_IRQ_EN
      chk("irq", irq, m_irq);
`endif
    end
  end

  logic last_slverr;

  task automatic apb_write(input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    last_slverr = bus.PSLVERR;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(negedge clk);
    d = bus.PRDATA;
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic run_op(output int nb, output int np, output int ne, output logic aok);
    nb = 0; np = 0; ne = 0; aok = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (!busy) return;
      nb++;
      if (flashprog) begin
        np++;
        if (flashaddr != 14'h0040) aok = 1'b0;
      end
      if (flasherase) ne++;
    end
    chk("op_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_prog();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flashprog) return;
    end
    chk("prog_timeout", 1'b1, 1'b0);
  endtask

  logic        rd_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rd_rand) rdaddr = 14'($urandom);
    end
  end

  logic [31:0] rd;
  int          nb, np, ne, n_erase, k;
  logic        aok, rose;
  logic [15:0] key;
  logic [1:0]  code;

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_flashaddr", flashaddr, 32'h1234);
    chk("reset_outputs", {flashprog, flasherase, busy, flashwdata}, 32'd0);
    apb_read(10'd3, rd);
    chk("reset_status", rd, 32'd0);

    apb_write(10'd0, 32'h0000_0040);
    apb_write(10'd1, 32'hDEAD_BEEF);
    apb_write(10'd2, 32'hA5A5_0001);
    run_op(nb, np, ne, aok);
    chk("prog_busy_len", nb, 44);
    chk("prog_pulse_len", np, 40);
    chk("prog_erase_len", ne, 0);
    chk("prog_flashaddr", aok, 1'b1);
    apb_read(10'd3, rd);
    chk("prog_status", rd, 32'h2);
    apb_write(10'd3, 32'h2);
    apb_read(10'd3, rd);
    chk("done_w1c", rd, 32'h0);

    apb_write(10'd2, 32'hA5A5_0002);
    run_op(nb, np, ne, aok);
    chk("erase_busy_len", nb, 4004);
    chk("erase_pulse_len", ne, 4000);
    chk("erase_prog_len", np, 0);
    apb_write(10'd3, 32'h2);

    apb_write(10'd2, 32'h1234_0001);
    rose = 1'b0;
    repeat (4) begin @(negedge clk); rose |= busy; end
    chk("badkey_busy", rose, 1'b0);
    apb_read(10'd3, rd);
    chk("badkey_status", rd, 32'h4);
    apb_write(10'd3, 32'h4);
    apb_read(10'd3, rd);
    chk("err_w1c", rd, 32'h0);
    apb_write(10'd2, 32'hA5A5_0003);
    rose = 1'b0;
    repeat (4) begin @(negedge clk); rose |= busy; end
    chk("badcode_busy", rose, 1'b0);
    apb_read(10'd3, rd);
    chk("badcode_status", rd, 32'h4);
    apb_write(10'd3, 32'h4);

    apb_write(10'd2, 32'hA5A5_0001);
    wait_prog();
    apb_write(10'd1, 32'h1111_1111);
    chk("busy_wr_slverr", last_slverr, 1'b1);
    @(negedge clk);
    chk("busy_wr_wdata", flashwdata, 32'hDEAD_BEEF);
    run_op(nb, np, ne, aok);
    apb_read(10'd3, rd);
    chk("busy_wr_status", rd, 32'h6);
    apb_write(10'd3, 32'h6);

    apb_write(10'd2, 32'hA5A5_0001);
    wait_prog();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_strobe", flashprog, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    apb_read(10'd3, rd);
    chk("rst_status", rd, 32'h0);
    @(negedge clk);
    chk("rst_flashaddr", flashaddr, 32'h1234);

`ifdef FLASH_PROG_CTRL_IRQ_EN
    apb_write(10'd4, 32'h1);
    apb_write(10'd2, 32'hA5A5_0001);
    run_op(nb, np, ne, aok);
    chk("irq_at_done", irq, 1'b0);
    @(negedge clk);
    chk("irq_after_done", irq, 1'b1);
    apb_write(10'd3, 32'h2);
`endif

    rd_rand = 1'b1;
    n_erase = 0;
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(9);
      if (k <= 1) apb_write(10'd0, $urandom);
      else if (k <= 3) apb_write(10'd1, $urandom);
      else if (k <= 6) begin
        key  = ($urandom_range(3) != 0) ? 16'hA5A5 : 16'($urandom);
        code = 2'($urandom_range(3));
        if (code == 2'd2 && n_erase >= 2) code = 2'd1;
        if (code == 2'd2 && key == 16'hA5A5) n_erase++;
        apb_write(10'd2, {key, 14'($urandom), code});
      end
      else if (k == 7) apb_write(10'd3, 32'($urandom_range(7)));
      else if (k == 8) apb_read(10'($urandom_range(5)), rd);
      else apb_write(($urandom_range(1) != 0) ? 10'd4 : 10'($urandom_range(1023, 5)), $urandom);
      repeat ($urandom_range(3)) @(posedge clk);
    end
    run_op(nb, np, ne, aok);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
